// File: rtl/round_health_if.sv
// Bus between the hit logic / display side and the round health controller.
interface round_health_if #(
    parameter int unsigned N_PLAYERS = 2,
    parameter int unsigned HP_W      = 8,
    parameter int unsigned WIN_W     = 2,
    parameter int unsigned PID_W     = 1
);
    logic [N_PLAYERS-1:0]       hit;
    logic                       restart;
    logic [N_PLAYERS*HP_W-1:0]  health;
    logic [N_PLAYERS-1:0]       invuln;
    logic [N_PLAYERS-1:0]       ko;
    logic [N_PLAYERS*WIN_W-1:0] round_wins;
    logic [1:0]                 state;
    logic                       new_round;
    logic [PID_W-1:0]           match_winner;
    logic                       match_over;

    modport master (
        output hit, restart,
        input  health, invuln, ko, round_wins, state, new_round, match_winner, match_over
    );

    modport slave (
        input  hit, restart,
        output health, invuln, ko, round_wins, state, new_round, match_winner, match_over
    );
endinterface

// File: rtl/round_health_ctrl.sv
// Per-fighter health with i-frames, knockout detection and a best-of-N round/match FSM.
module round_health_ctrl #(
    parameter int unsigned N_PLAYERS     = 2,
    parameter int unsigned HP_W          = 8,
    parameter int unsigned MAX_HP        = 200,
    parameter int unsigned DMG           = 10,
    parameter int unsigned IFRAMES       = 20,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned KO_HOLD       = 120,
    parameter int unsigned WIN_W         = $clog2(ROUNDS_TO_WIN + 1)
) (
    input  logic           Clk,
    input  logic           Reset,
    round_health_if.slave  bus
);
    localparam int unsigned PID_W  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam int unsigned IF_W   = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
    localparam int unsigned HOLD_W = (KO_HOLD > 1) ? $clog2(KO_HOLD + 1) : 1;
    localparam int unsigned CNT_W  = $clog2(N_PLAYERS + 1);

    localparam logic [1:0] FIGHT      = 2'b00;
    localparam logic [1:0] KO_WAIT    = 2'b01;
    localparam logic [1:0] MATCH_OVER = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PID_W-1:0]  winner_q, winner_d;
    logic              new_round_q, new_round_d;
    logic [HP_W-1:0]   health_q [N_PLAYERS];
    logic [HP_W-1:0]   health_d [N_PLAYERS];
    logic [IF_W-1:0]   ifr_q    [N_PLAYERS];
    logic [IF_W-1:0]   ifr_d    [N_PLAYERS];
    logic [WIN_W-1:0]  wins_q   [N_PLAYERS];
    logic [WIN_W-1:0]  wins_d   [N_PLAYERS];

    logic [CNT_W-1:0]  alive_cnt;
    logic [PID_W-1:0]  alive_idx;
    logic              champ_found;
    logic [PID_W-1:0]  champ_idx;

    // Next-state: damage/i-frames in FIGHT, round end on next-state health, hold and restart handling.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        winner_d    = winner_q;
        new_round_d = 1'b0;
        health_d    = health_q;
        ifr_d       = ifr_q;
        wins_d      = wins_q;
        alive_cnt   = '0;
        alive_idx   = '0;
        champ_found = 1'b0;
        champ_idx   = '0;

        case (state_q)
            FIGHT: begin
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (bus.hit[i] && (ifr_q[i] == '0)) begin
                        health_d[i] = (health_q[i] > HP_W'(DMG)) ? (health_q[i] - HP_W'(DMG)) : '0;
                        ifr_d[i]    = IF_W'(IFRAMES);
                    end else if (ifr_q[i] != '0) begin
                        ifr_d[i] = ifr_q[i] - IF_W'(1);
                    end
                end
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (health_d[i] != '0) begin
                        alive_cnt = alive_cnt + CNT_W'(1);
                        alive_idx = PID_W'(i);
                    end
                end
                // Fewer than two survivors ends the round; a lone survivor scores it.
                if (alive_cnt < CNT_W'(2)) begin
                    state_d = KO_WAIT;
                    hold_d  = HOLD_W'(KO_HOLD - 1);
                    if (alive_cnt == CNT_W'(1)) begin
                        wins_d[alive_idx] = wins_q[alive_idx] + WIN_W'(1);
                    end
                end
            end

            KO_WAIT: begin
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (ifr_q[i] != '0) begin
                        ifr_d[i] = ifr_q[i] - IF_W'(1);
                    end
                end
                if (hold_q == '0) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (wins_q[i] == WIN_W'(ROUNDS_TO_WIN)) begin
                            champ_found = 1'b1;
                            champ_idx   = PID_W'(i);
                        end
                    end
                    if (champ_found) begin
                        state_d  = MATCH_OVER;
                        winner_d = champ_idx;
                    end else begin
                        state_d     = FIGHT;
                        new_round_d = 1'b1;
                        for (int i = 0; i < N_PLAYERS; i++) begin
                            health_d[i] = HP_W'(MAX_HP);
                            ifr_d[i]    = '0;
                        end
                    end
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end

            MATCH_OVER: begin
                if (bus.restart) begin
                    state_d     = FIGHT;
                    new_round_d = 1'b1;
                    winner_d    = '0;
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        health_d[i] = HP_W'(MAX_HP);
                        ifr_d[i]    = '0;
                        wins_d[i]   = '0;
                    end
                end
            end

            default: begin
                state_d = FIGHT;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset to full health in FIGHT.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= FIGHT;
            hold_q      <= '0;
            winner_q    <= '0;
            new_round_q <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                health_q[i] <= HP_W'(MAX_HP);
                ifr_q[i]    <= '0;
                wins_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            winner_q    <= winner_d;
            new_round_q <= new_round_d;
            health_q    <= health_d;
            ifr_q       <= ifr_d;
            wins_q      <= wins_d;
        end
    end

    // Output packing; invuln and ko decode directly from the registers.
    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_out
        assign bus.health[g*HP_W +: HP_W]      = health_q[g];
        assign bus.round_wins[g*WIN_W +: WIN_W] = wins_q[g];
        assign bus.invuln[g]                   = (ifr_q[g] != '0);
        assign bus.ko[g]                       = (health_q[g] == '0);
    end

    assign bus.state        = state_q;
    assign bus.new_round    = new_round_q;
    assign bus.match_winner = winner_q;
    assign bus.match_over   = (state_q == MATCH_OVER);
endmodule

// File: tb/tb_round_health_ctrl.sv
// Bench for round_health_ctrl: directed scenarios plus random hits against a timestamp-based model.
module tb_round_health_ctrl;
    localparam int MAX_HP  = 200;
    localparam int DMG     = 10;
    localparam int IFRAMES = 20;
    localparam int ROUNDS  = 2;
    localparam int KO_HOLD = 120;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    round_health_if #(.N_PLAYERS(2), .HP_W(8), .WIN_W(2), .PID_W(1)) bus_a ();
    round_health_if #(.N_PLAYERS(2), .HP_W(8), .WIN_W(2), .PID_W(1)) bus_b ();

    round_health_ctrl u_dut_a (.Clk(clk), .Reset(rst), .bus(bus_a.slave));
    round_health_ctrl #(.MAX_HP(25), .DMG(10), .IFRAMES(0)) u_dut_b (.Clk(clk), .Reset(rst), .bus(bus_b.slave));

    always #5 clk = ~clk;

    // Reference model for u_dut_a: i-frames tracked as "ready at edge N", KO_WAIT as an end edge.
    int cyc = 0;
    int m_hp [2];
    int m_ready [2];
    int m_wins [2];
    int m_last, m_phase, m_ko_end, m_winner;
    bit m_nr;

    always @(posedge clk or posedge rst) begin
        int alive, who;
        bit found;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_hp[i] = MAX_HP; m_ready[i] = cyc; m_wins[i] = 0;
            end
            m_last = cyc - 1; m_phase = 0; m_winner = 0; m_nr = 0; m_ko_end = 0;
        end else begin
            m_nr = 0;
            if (m_phase == 0) begin
                for (int i = 0; i < 2; i++) begin
                    if (bus_a.hit[i] && cyc >= m_ready[i]) begin
                        m_hp[i]    = (m_hp[i] > DMG) ? m_hp[i] - DMG : 0;
                        m_ready[i] = cyc + IFRAMES + 1;
                    end
                end
                alive = 0; who = 0;
                for (int i = 0; i < 2; i++) if (m_hp[i] != 0) begin alive++; who = i; end
                if (alive < 2) begin
                    m_phase  = 1;
                    m_ko_end = cyc + KO_HOLD;
                    if (alive == 1) m_wins[who]++;
                end
            end else if (m_phase == 1) begin
                if (cyc == m_ko_end) begin
                    found = 0;
                    for (int i = 0; i < 2; i++) if (m_wins[i] == ROUNDS) begin found = 1; m_winner = i; end
                    if (found) m_phase = 2;
                    else begin
                        m_phase = 0; m_nr = 1;
                        for (int i = 0; i < 2; i++) begin m_hp[i] = MAX_HP; m_ready[i] = cyc + 1; end
                    end
                end
            end else if (bus_a.restart) begin
                m_phase = 0; m_nr = 1;
                for (int i = 0; i < 2; i++) begin m_hp[i] = MAX_HP; m_ready[i] = cyc + 1; m_wins[i] = 0; end
            end
            m_last = cyc;
            cyc++;
        end
    end

    function automatic logic [15:0] exp_health();
        logic [15:0] r;
        for (int i = 0; i < 2; i++) r[i*8 +: 8] = 8'(m_hp[i]);
        return r;
    endfunction

    function automatic logic [1:0] exp_invuln();
        logic [1:0] r;
        for (int i = 0; i < 2; i++) r[i] = (m_last < m_ready[i] - 1);
        return r;
    endfunction

    function automatic logic [1:0] exp_ko();
        logic [1:0] r;
        for (int i = 0; i < 2; i++) r[i] = (m_hp[i] == 0);
        return r;
    endfunction

    function automatic logic [3:0] exp_wins();
        logic [3:0] r;
        for (int i = 0; i < 2; i++) r[i*2 +: 2] = 2'(m_wins[i]);
        return r;
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.hit = '0; bus_a.restart = 1'b0;
        bus_b.hit = '0; bus_b.restart = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (bus_a.health !== 16'hC8C8) begin errors++; $display("FAIL reset_health got %h exp c8c8", bus_a.health); end
        checks++; if (bus_a.state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", bus_a.state); end
        checks++; if (bus_a.invuln !== 2'b00) begin errors++; $display("FAIL reset_invuln got %b exp 00", bus_a.invuln); end
        checks++; if (bus_a.ko !== 2'b00) begin errors++; $display("FAIL reset_ko got %b exp 00", bus_a.ko); end
        checks++; if (bus_a.round_wins !== 4'b0000) begin errors++; $display("FAIL reset_wins got %b exp 0000", bus_a.round_wins); end
        checks++; if (bus_a.new_round !== 1'b0 || bus_a.match_over !== 1'b0 || bus_a.match_winner !== 1'b0) begin
            errors++; $display("FAIL reset_flags got nr=%b mo=%b mw=%b exp 0 0 0", bus_a.new_round, bus_a.match_over, bus_a.match_winner);
        end
        checks++; if (bus_b.health !== 16'h1919) begin errors++; $display("FAIL reset_health_b got %h exp 1919", bus_b.health); end
    endtask

    task automatic test_hold_hit();
        int inv_cycles = 0;
        int exp0;
        bus_a.hit = 2'b01;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus_a.invuln[0]) inv_cycles++;
            checks++; if (bus_a.health !== exp_health()) begin errors++; $display("FAIL hold_model k=%0d got %h exp %h", k, bus_a.health, exp_health()); end
            if (k == 0 || k == 20 || k == 21 || k == 41 || k == 42) begin
                exp0 = MAX_HP - DMG * (k / (IFRAMES + 1) + 1);
                checks++; if (bus_a.health[7:0] !== 8'(exp0)) begin errors++; $display("FAIL hold_health0 k=%0d got %0d exp %0d", k, bus_a.health[7:0], exp0); end
            end
        end
        bus_a.hit = 2'b00;
        checks++; if (inv_cycles !== 48) begin errors++; $display("FAIL hold_invuln_cycles got %0d exp 48", inv_cycles); end
        checks++; if (bus_a.health[15:8] !== 8'd200) begin errors++; $display("FAIL hold_health1 got %0d exp 200", bus_a.health[15:8]); end
    endtask

    task automatic test_saturation();
        int exp1;
        bus_b.hit = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp1 = (k == 0) ? 15 : (k == 1) ? 5 : 0;
            checks++; if (bus_b.health[15:8] !== 8'(exp1)) begin errors++; $display("FAIL sat_health1 k=%0d got %0d exp %0d", k, bus_b.health[15:8], exp1); end
        end
        bus_b.hit = 2'b00;
        checks++; if (bus_b.ko !== 2'b10) begin errors++; $display("FAIL sat_ko got %b exp 10", bus_b.ko); end
        checks++; if (bus_b.state !== 2'b01) begin errors++; $display("FAIL sat_state got %b exp 01", bus_b.state); end
        checks++; if (bus_b.round_wins !== 4'b0001) begin errors++; $display("FAIL sat_wins got %b exp 0001", bus_b.round_wins); end
    endtask

    task automatic test_draw();
        int nr_pulses = 0;
        int ko_cycles = 0;
        pulse_reset();
        bus_a.hit = 2'b11;
        for (int k = 0; k < 399; k++) begin
            @(negedge clk);
            checks++; if (bus_a.health !== exp_health()) begin errors++; $display("FAIL draw_model k=%0d got %h exp %h", k, bus_a.health, exp_health()); end
        end
        checks++; if (bus_a.health !== 16'h0A0A) begin errors++; $display("FAIL draw_pre_health got %h exp 0a0a", bus_a.health); end
        checks++; if (bus_a.invuln !== 2'b00) begin errors++; $display("FAIL draw_pre_invuln got %b exp 00", bus_a.invuln); end
        @(negedge clk);
        bus_a.hit = 2'b00;
        checks++; if (bus_a.health !== 16'h0000) begin errors++; $display("FAIL draw_health got %h exp 0000", bus_a.health); end
        checks++; if (bus_a.ko !== 2'b11) begin errors++; $display("FAIL draw_ko got %b exp 11", bus_a.ko); end
        checks++; if (bus_a.state !== 2'b01) begin errors++; $display("FAIL draw_state got %b exp 01", bus_a.state); end
        checks++; if (bus_a.round_wins !== 4'b0000) begin errors++; $display("FAIL draw_wins got %b exp 0000", bus_a.round_wins); end
        for (int j = 1; j <= KO_HOLD; j++) begin
            @(negedge clk);
            if (bus_a.new_round) nr_pulses++;
            if (bus_a.state == 2'b01) ko_cycles++;
        end
        checks++; if (nr_pulses !== 1) begin errors++; $display("FAIL draw_new_round_pulses got %0d exp 1", nr_pulses); end
        checks++; if (ko_cycles !== KO_HOLD - 1) begin errors++; $display("FAIL draw_hold_len got %0d exp %0d", ko_cycles, KO_HOLD - 1); end
        checks++; if (bus_a.state !== 2'b00) begin errors++; $display("FAIL draw_after_state got %b exp 00", bus_a.state); end
        checks++; if (bus_a.health !== 16'hC8C8) begin errors++; $display("FAIL draw_after_health got %h exp c8c8", bus_a.health); end
    endtask

    task automatic test_match();
        bit seen;
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            seen = 1'b0;
            bus_a.hit = 2'b01;
            for (int k = 0; k < 500 && !seen; k++) begin
                @(negedge clk);
                checks++; if (bus_a.health !== exp_health()) begin errors++; $display("FAIL match_model r=%0d k=%0d got %h exp %h", r, k, bus_a.health, exp_health()); end
                if (bus_a.state == 2'b01) seen = 1'b1;
            end
            bus_a.hit = 2'b00;
            checks++; if (!seen) begin errors++; $display("FAIL match_ko_timeout r=%0d got state %b exp 01", r, bus_a.state); end
            checks++; if (bus_a.round_wins !== {2'(r + 1), 2'b00}) begin errors++; $display("FAIL match_wins r=%0d got %b exp %b", r, bus_a.round_wins, {2'(r + 1), 2'b00}); end
            seen = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                if (bus_a.state != 2'b01) seen = 1'b1;
            end
            checks++; if (!seen) begin errors++; $display("FAIL match_hold_timeout r=%0d got state %b", r, bus_a.state); end
            checks++; if (bus_a.state !== ((r == 0) ? 2'b00 : 2'b10)) begin errors++; $display("FAIL match_after_hold r=%0d got %b", r, bus_a.state); end
        end
        checks++; if (bus_a.match_over !== 1'b1) begin errors++; $display("FAIL match_over got %b exp 1", bus_a.match_over); end
        checks++; if (bus_a.match_winner !== 1'b1) begin errors++; $display("FAIL match_winner got %b exp 1", bus_a.match_winner); end
        bus_a.hit = 2'b11;
        repeat (30) @(negedge clk);
        bus_a.hit = 2'b00;
        checks++; if (bus_a.health !== 16'hC800) begin errors++; $display("FAIL over_health got %h exp c800", bus_a.health); end
        checks++; if (bus_a.state !== 2'b10 || bus_a.round_wins !== 4'b1000) begin
            errors++; $display("FAIL over_hold got state %b wins %b exp 10 1000", bus_a.state, bus_a.round_wins);
        end
        bus_a.restart = 1'b1;
        @(negedge clk);
        bus_a.restart = 1'b0;
        checks++; if (bus_a.round_wins !== 4'b0000) begin errors++; $display("FAIL restart_wins got %b exp 0000", bus_a.round_wins); end
        checks++; if (bus_a.state !== 2'b00) begin errors++; $display("FAIL restart_state got %b exp 00", bus_a.state); end
        checks++; if (bus_a.health !== 16'hC8C8) begin errors++; $display("FAIL restart_health got %h exp c8c8", bus_a.health); end
        checks++; if (bus_a.new_round !== 1'b1) begin errors++; $display("FAIL restart_pulse got %b exp 1", bus_a.new_round); end
        @(negedge clk);
        checks++; if (bus_a.new_round !== 1'b0) begin errors++; $display("FAIL restart_pulse_end got %b exp 0", bus_a.new_round); end
    endtask

    task automatic test_reset_mid_ko();
        pulse_reset();
        bus_b.hit = 2'b10;
        repeat (3) @(negedge clk);
        bus_b.hit = 2'b00;
        repeat (30) @(negedge clk);
        checks++; if (bus_b.state !== 2'b01) begin errors++; $display("FAIL midko_pre_state got %b exp 01", bus_b.state); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus_b.health !== 16'h1919 || bus_b.state !== 2'b00 || bus_b.round_wins !== 4'b0000) begin
            errors++; $display("FAIL midko_reset got health %h state %b wins %b exp 1919 00 0000", bus_b.health, bus_b.state, bus_b.round_wins);
        end
        checks++; if (bus_b.ko !== 2'b00 || bus_b.invuln !== 2'b00 || bus_b.new_round !== 1'b0 || bus_b.match_over !== 1'b0 || bus_b.match_winner !== 1'b0) begin
            errors++; $display("FAIL midko_reset_flags got ko %b inv %b nr %b mo %b mw %b exp all 0", bus_b.ko, bus_b.invuln, bus_b.new_round, bus_b.match_over, bus_b.match_winner);
        end
        checks++; if (bus_a.health !== 16'hC8C8) begin errors++; $display("FAIL midko_reset_a got %h exp c8c8", bus_a.health); end
        @(negedge clk);
        rst = 1'b0;
        bus_b.hit = 2'b10;
        bus_a.hit = 2'b01;
        @(negedge clk);
        bus_b.hit = 2'b00;
        bus_a.hit = 2'b00;
        checks++; if (bus_b.health !== 16'h0F19) begin errors++; $display("FAIL midko_resume_b got %h exp 0f19", bus_b.health); end
        checks++; if (bus_a.health !== 16'hC8BE) begin errors++; $display("FAIL midko_resume_a got %h exp c8be", bus_a.health); end
    endtask

    task automatic test_random();
        int overs = 0;
        pulse_reset();
        for (int k = 0; k < 4000; k++) begin
            bus_a.hit     = 2'($urandom_range(0, 3));
            bus_a.restart = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            checks++; if (bus_a.health !== exp_health()) begin errors++; $display("FAIL rand_health k=%0d got %h exp %h", k, bus_a.health, exp_health()); end
            checks++; if (bus_a.invuln !== exp_invuln()) begin errors++; $display("FAIL rand_invuln k=%0d got %b exp %b", k, bus_a.invuln, exp_invuln()); end
            checks++; if (bus_a.ko !== exp_ko()) begin errors++; $display("FAIL rand_ko k=%0d got %b exp %b", k, bus_a.ko, exp_ko()); end
            checks++; if (bus_a.round_wins !== exp_wins()) begin errors++; $display("FAIL rand_wins k=%0d got %b exp %b", k, bus_a.round_wins, exp_wins()); end
            checks++; if (bus_a.state !== 2'(m_phase)) begin errors++; $display("FAIL rand_state k=%0d got %b exp %0d", k, bus_a.state, m_phase); end
            checks++; if (bus_a.new_round !== m_nr) begin errors++; $display("FAIL rand_new_round k=%0d got %b exp %b", k, bus_a.new_round, m_nr); end
            checks++; if (bus_a.match_over !== (m_phase == 2)) begin errors++; $display("FAIL rand_match_over k=%0d got %b exp %0d", k, bus_a.match_over, m_phase); end
            if (m_phase == 2) begin
                overs++;
                checks++; if (bus_a.match_winner !== 1'(m_winner)) begin errors++; $display("FAIL rand_winner k=%0d got %b exp %0d", k, bus_a.match_winner, m_winner); end
            end
        end
        bus_a.hit = 2'b00;
        bus_a.restart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hold_hit();
        test_saturation();
        test_draw();
        test_match();
        test_reset_mid_ko();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/round_health_ctrl.md
# round_health_ctrl

Parametrised successor to the per-fighter health bar. It tracks health for N_PLAYERS fighters and enforces invulnerability frames after each hit. It also detects knockouts, runs a best-of-N round/match state machine, and restores health between rounds. It sits between the punch/hit logic (hit pulses in) and the color mapper/HEX display (health, win counts and match status out), and is clocked by the frame clock.

## Interface
- N_PLAYERS, 2, number of fighters (≥2)
- HP_W, 8, health register width per player
- MAX_HP, 200, full health; must be < 2**HP_W
- DMG, 10, health removed per accepted hit
- IFRAMES, 20, invulnerability cycles loaded after an accepted hit
- ROUNDS_TO_WIN, 2, round wins needed to take the match
- KO_HOLD, 120, cycles frozen after a round ends
- WIN_W, $clog2(ROUNDS_TO_WIN+1), derived round-win counter width

Ports:
- Clk  in  1  frame clock
- Reset  in  1  asynchronous, active-high reset
- hit  in  N_PLAYERS  bit i high = player i struck this cycle
- restart  in  1  starts a new match; honoured only in MATCH_OVER
- health  out  N_PLAYERS*HP_W  player i at [i*HP_W +: HP_W]
- invuln  out  N_PLAYERS  i-frame counter of player i nonzero
- ko  out  N_PLAYERS  health of player i == 0 (decoded from register)
- round_wins  out  N_PLAYERS*WIN_W  per-player round win counts
- state  out  2  00 FIGHT, 01 KO_WAIT, 10 MATCH_OVER
- new_round  out  1  one-cycle pulse on the edge entering FIGHT from KO_WAIT
- match_winner  out  $clog2(N_PLAYERS)  valid while in MATCH_OVER
- match_over  out  1  state == MATCH_OVER

## Operation
- Reset values:
  - health = MAX_HP for all players
  - i-frame counters, invuln, ko, round_wins, new_round and match_winner = 0
  - state = FIGHT
- FIGHT, per player i:
  - A hit is accepted when hit[i]=1 and the i-frame counter is 0.
  - Accepted hit: health -= DMG, saturating at 0, and the counter loads IFRAMES.
  - Otherwise a nonzero counter decrements by 1.
  - Players are independent. Several players may be hit on the same edge.
- Round end: evaluated on the same edge using next-state health. Alive = next health ≠ 0.
  - Exactly 1 alive: that player's round_wins increments and state goes to KO_WAIT.
  - 0 alive (simultaneous KO): a draw. No win is awarded and state goes to KO_WAIT.
  - ≥2 alive: remain in FIGHT.
- KO_WAIT:
  - hit is ignored, health is frozen, and i-frame counters keep counting down to 0.
  - A hold counter runs for exactly KO_HOLD cycles.
  - Leaving KO_WAIT when some round_wins == ROUNDS_TO_WIN:
    - state goes to MATCH_OVER and match_winner = that player.
  - Leaving KO_WAIT otherwise:
    - state goes to FIGHT, all health = MAX_HP, all counters cleared, new_round pulses.
- MATCH_OVER:
  - hit is ignored and all outputs hold.
  - restart=1 resets health, counters and round_wins, sets state to FIGHT and pulses new_round.
- restart outside MATCH_OVER is ignored.

## Timing
- All state updates on the rising Clk edge. Reset acts immediately, independent of Clk.
- Hit latency:
  - A hit sampled at edge k shows its health change after edge k.
  - invuln rises after edge k.
  - ko is combinational from the health register, so no added latency.
- A hit held high is accepted every IFRAMES+1 edges (edges k, k+IFRAMES+1, …).
- The KO_WAIT entry edge and the win increment coincide with the killing hit.
- FIGHT is re-entered on edge k+KO_HOLD, where k is the entry edge.
- Reset mid-KO_WAIT or mid-MATCH_OVER returns every output to its reset value at once.

## Test plan
- Reset, then idle 10 cycles:
  - health 200/200, state 00, invuln 00, ko 00, round_wins 0/0.
- hit[0] held 50 cycles from edge 0:
  - health0 is 190 after edge 0, 180 after edge 21, 170 after edge 42.
  - invuln[0] is high 20 cycles per hit.
  - health1 stays 200.
- Saturation with MAX_HP=25, DMG=10, IFRAMES=0; hit[1] on 3 consecutive edges:
  - health1 reads 15, then 5, then 0.
  - ko[1]=1, state=01, round_wins[0]=1.
- Both players at 10 (MAX_HP=200), hit=11 on one edge:
  - both health 0, state 01, round_wins unchanged.
  - After 120 cycles: health 200/200, new_round pulses once, state 00.
- Player 1 wins two rounds:
  - After the second KO_HOLD: state 10, match_over=1, match_winner=1.
  - hit has no effect.
  - A restart pulse gives round_wins 0/0, state 00, health 200/200.
- Reset asserted 30 cycles into KO_WAIT:
  - All outputs return to reset values before the next Clk edge.
  - Normal FIGHT behaviour resumes after deassert.
